// File: rtl/dsp48a1_mac_sequencer_if.sv
// Operand stream and result port between the MAC sequencer and its
// neighbours: operand pairs flow in on s_*, the finished dot product
// flows out on m_*.
interface dsp48a1_mac_sequencer_if;
    logic               s_valid;
    logic               s_ready;
    logic signed [17:0] s_a;
    logic signed [17:0] s_b;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic signed [47:0] m_result;
    logic               m_trunc;

    // Operand source / result consumer side.
    modport master (
        output s_valid, s_a, s_b, s_last, m_ready,
        input  s_ready, m_valid, m_result, m_trunc
    );

    // Sequencer side.
    modport slave (
        input  s_valid, s_a, s_b, s_last, m_ready,
        output s_ready, m_valid, m_result, m_trunc
    );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice (A1/B1, M, P and OPMODE registers enabled) as a
// signed multiply-accumulate engine. Operands go straight to the slice; the
// OPMODE word is registered so it meets the products at the P stage, and a
// 3-deep tag pipeline follows each term through the slice so the result is
// captured as the final term leaves P.
module dsp48a1_mac_sequencer #(
    parameter int          MAX_TERMS = 4096,
    parameter logic [7:0]  OP_FIRST  = 8'b00000001,
    parameter logic [7:0]  OP_ACC    = 8'b00001001,
    parameter logic [7:0]  OP_HOLD   = 8'b00001000
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    dsp48a1_mac_sequencer_if.slave    bus,
    output logic                      busy,
    output logic signed [17:0]        DSP_A,
    output logic signed [17:0]        DSP_B,
    output logic [7:0]                DSP_OPMODE,
    output logic                      DSP_CE,
    output logic                      DSP_RST,
    input  logic signed [47:0]        DSP_P
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
        logic trunc;
    } tag_t;

    // Count value held while the MAX_TERMS-th pair is being accepted.
    localparam logic [11:0] LAST_COUNT = 12'(MAX_TERMS - 1);

    state_t      state;
    state_t      state_next;
    logic [11:0] term_count;
    tag_t        tag_in;
    tag_t [2:0]  tag_q;
    logic        accept;
    logic        at_limit;
    logic        end_of_input;
    logic        result_done;

    assign DSP_A        = bus.s_a;
    assign DSP_B        = bus.s_b;
    assign accept       = bus.s_valid && bus.s_ready;
    assign at_limit     = (term_count == LAST_COUNT);
    assign end_of_input = accept && (bus.s_last || at_limit);
    assign result_done  = tag_q[2].valid && tag_q[2].last;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept terms until last/limit, wait for the final
    // tag to leave the P stage, then hold the result until it is taken.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no
        // latch is inferred.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = end_of_input ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (end_of_input) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (result_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; inputs are refused while the
    // slice is still in its synchronous reset.
    always_comb begin
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        busy        = (state != IDLE);
        unique case (state)
            IDLE, ACCUM: bus.s_ready = !DSP_RST;
            HOLD:        bus.m_valid = 1'b1;
            default:     bus.s_ready = 1'b0;
        endcase
    end

    // Slice control: CE rises on the first edge after reset with RST still
    // high so the slice clears synchronously; RST drops on the second edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DSP_CE  <= 1'b0;
            DSP_RST <= 1'b1;
        end else begin
            DSP_CE  <= 1'b1;
            DSP_RST <= !DSP_CE;
        end
    end

    // OPMODE is registered at the accept edge so the slice's OPMODE
    // register presents it alongside the matching M value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DSP_OPMODE <= OP_HOLD;
        end else if (accept) begin
            DSP_OPMODE <= (term_count == 12'd0) ? OP_FIRST : OP_ACC;
        end else begin
            DSP_OPMODE <= OP_HOLD;
        end
    end

    // Terms accepted in the current accumulation; cleared on return to IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            term_count <= 12'd0;
        end else if (state_next == IDLE && state != IDLE) begin
            term_count <= 12'd0;
        end else if (accept) begin
            term_count <= term_count + 12'd1;
        end
    end

    // Tag for the term entering the slice this cycle.
    always_comb begin
        tag_in.valid = accept;
        tag_in.last  = end_of_input;
        tag_in.trunc = accept && at_limit && !bus.s_last;
    end

    // Tag pipeline mirrors A1/B1 -> M/OPMODE -> P; it shifts every cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[1:0], tag_in};
        end
    end

    // Capture P as the final tag exits; held stable while in HOLD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.m_result <= '0;
            bus.m_trunc  <= 1'b0;
        end else if (state == DRAIN && result_done) begin
            bus.m_result <= DSP_P;
            bus.m_trunc  <= tag_q[2].trunc;
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench: the sequencer drives a behavioural DSP48A1 model
// (A1/B1, M, P, OPMODE registers, sync reset). Expected dot products are
// queued as the final term of each accumulation is driven and compared by a
// monitor when the result handshake happens.
module tb_dsp48a1_mac_sequencer;

    localparam int         MAX_TERMS = 4;
    localparam logic [7:0] OP_FIRST  = 8'b00000001;
    localparam logic [7:0] OP_HOLD   = 8'b00001000;

    typedef struct {
        logic [47:0] result;
        logic        trunc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               busy;
    logic signed [17:0] dsp_a;
    logic signed [17:0] dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_ce;
    logic               dsp_rst;
    logic signed [47:0] dsp_p;

    dsp48a1_mac_sequencer_if bus();

    dsp48a1_mac_sequencer #(.MAX_TERMS(MAX_TERMS)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .DSP_A     (dsp_a),
        .DSP_B     (dsp_b),
        .DSP_OPMODE(dsp_opmode),
        .DSP_CE    (dsp_ce),
        .DSP_RST   (dsp_rst),
        .DSP_P     (dsp_p)
    );

    always #5 clk = ~clk;

    // Behavioural slice: A1/B1 -> M -> P with registered OPMODE.
    logic signed [17:0] a1_q;
    logic signed [17:0] b1_q;
    logic signed [35:0] m_q;
    logic [7:0]         opm_q;
    logic signed [47:0] p_q;
    logic signed [47:0] x_mux;
    logic signed [47:0] z_mux;

    always_comb begin
        x_mux = '0;
        z_mux = '0;
        if (opm_q[1:0] == 2'b01) x_mux = {{12{m_q[35]}}, m_q};
        if (opm_q[3:2] == 2'b10) z_mux = p_q;
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            a1_q  <= '0;
            b1_q  <= '0;
            m_q   <= '0;
            opm_q <= '0;
            p_q   <= '0;
        end else if (dsp_ce) begin
            a1_q  <= dsp_a;
            b1_q  <= dsp_b;
            m_q   <= a1_q * b1_q;
            opm_q <= dsp_opmode;
            p_q   <= z_mux + x_mux;
        end
    end
    assign dsp_p = p_q;

    // Bookkeeping.
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     n_seen   = 0;
    int     rise_cyc = 0;
    int     last_acc_cyc = 0;
    logic   m_valid_prev = 1'b0;
    longint model_acc   = 0;
    int     model_terms = 0;
    exp_t   exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic abort(input string tag);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", tag);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "bench stopped");
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Drive one pair, update the reference sum, wait for acceptance.
    task automatic send(input int a, input int b, input logic last);
        exp_t e;
        bus.s_valid = 1'b1;
        bus.s_a     = 18'(a);
        bus.s_b     = 18'(b);
        bus.s_last  = last;
        model_acc   = model_acc + longint'(a) * longint'(b);
        model_terms = model_terms + 1;
        if (last || model_terms == MAX_TERMS) begin
            e.result = 48'(model_acc);
            e.trunc  = !last;
            exp_q.push_back(e);
            model_acc   = 0;
            model_terms = 0;
        end
        for (int i = 0; i <= 200; i++) begin
            if (i == 200) abort("send_wait_ready");
            if (bus.s_ready) break;
            tick();
        end
        last_acc_cyc = cyc + 1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i <= 200; i++) begin
            if (i == 200) abort("wait_result");
            if (n_seen >= n) break;
            tick();
        end
    endtask

    // Result monitor: samples just before the edge where a handshake lands.
    always begin
        @(negedge clk);
        #2;
        if (bus.m_valid && !m_valid_prev) rise_cyc = cyc;
        m_valid_prev = bus.m_valid;
        if (bus.m_valid && bus.m_ready) begin
            n_seen++;
            check("result_expected", 48'(exp_q.size() != 0), 48'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_result", bus.m_result, e.result);
                check("m_trunc", 48'(bus.m_trunc), 48'(e.trunc));
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset held for 3 cycles.
        repeat (3) tick();
        check("rst_m_valid", 48'(bus.m_valid), 48'd0);
        check("rst_s_ready", 48'(bus.s_ready), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_dsp_rst", 48'(dsp_rst), 48'd1);
        check("rst_dsp_ce", 48'(dsp_ce), 48'd0);
        check("rst_opmode", 48'(dsp_opmode), 48'(OP_HOLD));
        check("rst_m_result", bus.m_result, 48'd0);
        rst_n = 1'b1;
        tick();
        check("edge1_dsp_rst", 48'(dsp_rst), 48'd1);
        check("edge1_dsp_ce", 48'(dsp_ce), 48'd1);
        check("edge1_s_ready", 48'(bus.s_ready), 48'd0);
        tick();
        check("edge2_dsp_rst", 48'(dsp_rst), 48'd0);
        check("edge2_s_ready", 48'(bus.s_ready), 48'd1);
        check("edge2_dsp_p", dsp_p, 48'd0);
        check("edge2_m_valid", 48'(bus.m_valid), 48'd0);

        // Basic dot product, back-to-back.
        bus.s_a = 18'd9;
        #1;
        check("dsp_a_passthru", 48'(dsp_a), 48'd9);
        send(3, 4, 1'b0);
        check("first_opmode", 48'(dsp_opmode), 48'(OP_FIRST));
        check("accum_busy", 48'(busy), 48'd1);
        send(5, 6, 1'b1);
        wait_results(1);
        check("basic_latency", 48'(rise_cyc - last_acc_cyc), 48'd3);

        // Signed single terms; the second proves OP_FIRST discards old P.
        send(-2, 7, 1'b1);
        wait_results(2);
        send(100, 100, 1'b1);
        wait_results(3);

        // Bubbles inside an accumulation.
        send(1, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bubble_opmode", 48'(dsp_opmode), 48'(OP_HOLD));
        end
        send(2, 2, 1'b1);
        wait_results(4);

        // Backpressure on the result port.
        bus.m_ready = 1'b0;
        send(7, 8, 1'b1);
        for (int i = 0; i <= 50; i++) begin
            if (i == 50) abort("bp_wait_valid");
            if (bus.m_valid) break;
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            check("bp_m_valid", 48'(bus.m_valid), 48'd1);
            check("bp_m_result", bus.m_result, 48'd56);
            check("bp_s_ready", 48'(bus.s_ready), 48'd0);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        check("bp_after_m_valid", 48'(bus.m_valid), 48'd0);
        check("bp_after_s_ready", 48'(bus.s_ready), 48'd1);
        wait_results(5);

        // Truncation at MAX_TERMS; the 5th pair opens a new accumulation.
        for (int i = 0; i < 4; i++) send(1, 1, 1'b0);
        send(1, 1, 1'b0);
        check("trunc_next_first", 48'(dsp_opmode), 48'(OP_FIRST));
        wait_results(6);

        // Reset mid-accumulation discards the in-flight term.
        rst_n = 1'b0;
        model_acc   = 0;
        model_terms = 0;
        tick();
        check("midrst_busy", 48'(busy), 48'd0);
        check("midrst_m_valid", 48'(bus.m_valid), 48'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_s_ready", 48'(bus.s_ready), 48'd1);
        for (int i = 0; i < 5; i++) begin
            check("midrst_no_valid", 48'(bus.m_valid), 48'd0);
            tick();
        end
        check("midrst_dsp_p", dsp_p, 48'd0);
        send(2, 3, 1'b1);
        wait_results(7);
        tick();

        check("results_seen", 48'(n_seen), 48'd7);
        check("queue_empty", 48'(exp_q.size()), 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
